i2s_rx_capture: RTL

I2S_RX_CAPTURE -- requirements
Module: i2s_rx_capture

---
 rtl/i2s_rx_capture.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_capture.sv
// I2S receive capture into a 32-bit read FIFO for a Xillybus-style stream.
// The three codec signals are resynchronized into bus_clk. Slots are captured
// MSB first with the I2S one-bit delay, and completed words are queued.
// Optional feature macro: I2S_RX_STEREO_PACK_EN packs one left/right frame
// into a single word {left[23:8], right[23:8]}.
module i2s_rx_capture #(
  parameter int FIFO_AW     = 4,
  parameter int SAMPLE_BITS = 24
) (
  input  logic        bus_clk,
  input  logic        rst_b,
  input  logic        i2s_bclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdata,
  input  logic        user_r_audio_rden,
  input  logic        user_r_audio_open,
  output logic        user_r_audio_empty,
  output logic [31:0] user_r_audio_data,
  output logic        user_r_audio_eof,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_BITS - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_LR,
    SHIFT,
    HOLD
  } cap_state_t;

  // Synchronizer and history flops
  logic bclk_s1, bclk_s2, bclk_d;
  logic lr_s1, lr_s2;
  logic sd_s1, sd_s2;
  logic lr_prev;
  logic lr_primed;
  logic bclk_ev;
  logic lr_edge;

  // Capture state
  cap_state_t state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic                   channel;
  logic                   start;
  logic                   shift_en;
  logic                   complete;
  logic                   abort;
  logic                   done_q;
  logic [23:0]            sample24;

  // Write request toward the FIFO
  logic        wr_req;
  logic [31:0] wr_word;

  // FIFO
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               rd_fire;
  logic               wr_try;
  logic               wr_fire;
  logic               drop;

  // Two-flop synchronizers for all codec inputs plus bclk history
  always_ff @(posedge bus_clk) begin
    if (!rst_b) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_d  <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      bclk_s1 <= i2s_bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lr_s1   <= i2s_lrclk;
      lr_s2   <= lr_s1;
      sd_s1   <= i2s_sdata;
      sd_s2   <= sd_s1;
    end
  end

  assign bclk_ev = bclk_s2 & ~bclk_d;

  // lrclk history at bclk events; the first event after reset only primes it
  // so capture resumes from a real word-clock transition.
  always_ff @(posedge bus_clk) begin
    if (!rst_b) begin
      lr_prev   <= 1'b0;
      lr_primed <= 1'b0;
    end else if (bclk_ev) begin
      lr_prev   <= lr_s2;
      lr_primed <= 1'b1;
    end
  end

  assign lr_edge = bclk_ev & lr_primed & (lr_s2 != lr_prev);

  // Capture FSM state register
  always_ff @(posedge bus_clk) begin
    if (!rst_b) begin
      state <= WAIT_LR;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture FSM next-state and datapath controls
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    if (lr_edge) begin
      start     = 1'b1;
      abort     = (state == SHIFT);
      state_nxt = SHIFT;
    end else if (bclk_ev && (state == SHIFT)) begin
      shift_en = 1'b1;
      if (bit_cnt == LAST_BIT) begin
        complete  = 1'b1;
        state_nxt = HOLD;
      end
    end
  end

  // Bit counter, shift register, channel latch and completion pulse
  always_ff @(posedge bus_clk) begin
    if (!rst_b) begin
      bit_cnt <= '0;
      shreg   <= '0;
      channel <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= complete;
      if (start) begin
        bit_cnt <= '0;
        channel <= lr_s2;
      end else if (shift_en) begin
        shreg   <= {shreg[SAMPLE_BITS-2:0], sd_s2};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Left-justify the captured sample into a 24-bit field
  always_comb begin
    sample24 = '0;
    for (int unsigned k = 0; k < 24; k++) begin
      if (k < SAMPLE_BITS) begin
        sample24[23-k] = shreg[SAMPLE_BITS-1-k];
      end
    end
  end

`ifdef I2S_RX_STEREO_PACK_EN
  logic [15:0] left_hold;
  logic        left_valid;

  // Track a completed left slot waiting for its right partner. A new left
  // slot or an aborted right slot invalidates it.
  always_ff @(posedge bus_clk) begin
    if (!rst_b) begin
      left_hold  <= '0;
      left_valid <= 1'b0;
    end else if (done_q) begin
      if (!channel) begin
        left_hold  <= sample24[23:8];
        left_valid <= 1'b1;
      end else begin
        left_valid <= 1'b0;
      end
    end else if ((start && !lr_s2) || (abort && channel)) begin
      left_valid <= 1'b0;
    end
  end

  // Emit a packed word only when a right slot completes after its left slot
  always_comb begin
    wr_req  = done_q & channel & left_valid;
    wr_word = {left_hold, sample24[23:8]};
  end
`else
  // One word per completed slot, channel in bit 0
  always_comb begin
    wr_req  = done_q;
    wr_word = {sample24, 7'b0, channel};
  end
`endif

  assign full    = (count == FULL_CNT);
  assign rd_fire = user_r_audio_rden & (count != '0);
  assign wr_try  = wr_req & user_r_audio_open;
  // A full FIFO still accepts a write when a read frees a slot the same cycle
  assign wr_fire = wr_try & (~full | rd_fire);
  assign drop    = wr_try & full & ~rd_fire;

  // FIFO storage
  always_ff @(posedge bus_clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // FIFO pointers, occupancy, registered read data and sticky overflow
  always_ff @(posedge bus_clk) begin
    if (!rst_b) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      user_r_audio_data <= '0;
      overflow          <= 1'b0;
    end else begin
      if (rd_fire) begin
        user_r_audio_data <= mem[rd_ptr];
      end
      if (!user_r_audio_open) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_fire) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_fire) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({wr_fire, rd_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign user_r_audio_empty = (count == '0);
  assign user_r_audio_eof   = 1'b0;

endmodule
